// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind a UART receiver: captures each frame and its error flags on the rising
// edge of done, and returns them through a registered read port with status reporting.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          done,
    input  logic [7:0]    data_in,
    input  logic          start_err,
    input  logic          stop_err,
    input  logic          data_err,
    input  logic          rd_en,
    input  logic          clr_status,
    output logic [7:0]    rd_data,
    output logic [2:0]    rd_err,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    output logic [7:0]    err_cnt
);

    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    logic [10:0]   mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          done_q;
    logic [7:0]    rd_data_q, rd_data_d;
    logic [2:0]    rd_err_q, rd_err_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          empty_w, full_w;
    logic          wr_req, rd_acc, wr_acc, wr_drop;
    logic [10:0]   wr_entry;
    logic [10:0]   rd_entry;

    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == FullCnt);
    assign wr_req   = done & ~done_q;
    assign rd_acc   = rd_en & ~empty_w;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign wr_acc   = wr_req & (~full_w | rd_acc);
    assign wr_drop  = wr_req & ~wr_acc;
    assign wr_entry = {start_err, stop_err, data_err, data_in};
    assign rd_entry = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_err_d   = rd_err_q;
        rd_valid_d = 1'b0;
        overrun_d  = overrun_q;
        err_cnt_d  = err_cnt_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_data_d  = rd_entry[7:0];
            rd_err_d   = rd_entry[10:8];
            rd_valid_d = 1'b1;
        end

        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (!wr_acc && rd_acc) begin
            count_d = count_q - 1'b1;
        end

        // New events take priority over a coincident clear.
        if (wr_drop) begin
            overrun_d = 1'b1;
        end else if (clr_status) begin
            overrun_d = 1'b0;
        end

        if (wr_acc && (wr_entry[10:8] != 3'b000)) begin
            if (clr_status) begin
                err_cnt_d = 8'd1;
            end else if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end else if (clr_status) begin
            err_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            rd_data_q  <= 8'd0;
            rd_err_q   <= 3'd0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            done_q     <= done;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_err   = rd_err_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_w;
    assign full     = full_w;
    assign count    = count_q;
    assign overrun  = overrun_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: ordering, edge detect, overrun, errors, reset.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rstn, done, start_err, stop_err, data_err, rd_en, clr_status;
    logic [7:0] data_in;
    logic [7:0] rd_data;
    logic [2:0] rd_err;
    logic       rd_valid, empty, full, overrun;
    logic [4:0] count;
    logic [7:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .done       (done),
        .data_in    (data_in),
        .start_err  (start_err),
        .stop_err   (stop_err),
        .data_err   (data_err),
        .rd_en      (rd_en),
        .clr_status (clr_status),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overrun    (overrun),
        .err_cnt    (err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame: done high for one cycle, then low for one cycle.
    task automatic send(input logic [7:0] b, input logic [2:0] e);
        done = 1'b1;
        data_in = b;
        {start_err, stop_err, data_err} = e;
        tick();
        done = 1'b0;
        {start_err, stop_err, data_err} = 3'b000;
        tick();
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] b, input logic [2:0] e);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(rd_data), 32'(b));
        chk({tag, "_err"}, 32'(rd_err), 32'(e));
        tick();
        chk({tag, "_vlow"}, 32'(rd_valid), 32'd0);
    endtask

    initial begin
        rstn = 1'b1; done = 1'b0; data_in = 8'h00; start_err = 1'b0; stop_err = 1'b0;
        data_err = 1'b0; rd_en = 1'b0; clr_status = 1'b0;
        #1 rstn = 1'b0;
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_errcnt", 32'(err_cnt), 32'd0);
        chk("rst_rddata", 32'(rd_data), 32'd0);
        rstn = 1'b1;
        tick();

        // 1: three clean frames in order
        send(8'h41, 3'b000);
        send(8'h42, 3'b000);
        send(8'h43, 3'b000);
        chk("t1_count", 32'(count), 32'd3);
        rd_chk("t1_r0", 8'h41, 3'b000);
        rd_chk("t1_r1", 8'h42, 3'b000);
        rd_chk("t1_r2", 8'h43, 3'b000);
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_errcnt", 32'(err_cnt), 32'd0);

        // read while empty is ignored
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("empty_rd_valid", 32'(rd_valid), 32'd0);
        chk("empty_rd_count", 32'(count), 32'd0);

        // 2: done held high for 20 cycles gives one entry
        done = 1'b1;
        data_in = 8'h55;
        for (int i = 0; i < 20; i++) tick();
        done = 1'b0;
        tick();
        chk("t2_count", 32'(count), 32'd1);
        rd_chk("t2_r", 8'h55, 3'b000);

        // 3: overflow by one frame
        for (int i = 0; i < 16; i++) send(8'(i + 1), 3'b000);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_count16", 32'(count), 32'd16);
        chk("t3_ovr_pre", 32'(overrun), 32'd0);
        send(8'd17, 3'b000);
        chk("t3_count", 32'(count), 32'd16);
        chk("t3_overrun", 32'(overrun), 32'd1);
        for (int i = 0; i < 16; i++) rd_chk($sformatf("t3_r%0d", i), 8'(i + 1), 3'b000);
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_ovr_sticky", 32'(overrun), 32'd1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("t3_ovr_clr", 32'(overrun), 32'd0);

        // 4: write and read in the same cycle while full
        for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 3'b000);
        done = 1'b1;
        data_in = 8'hEE;
        rd_en = 1'b1;
        tick();
        done = 1'b0;
        rd_en = 1'b0;
        chk("t4_valid", 32'(rd_valid), 32'd1);
        chk("t4_data", 32'(rd_data), 32'h80);
        chk("t4_count", 32'(count), 32'd16);
        chk("t4_overrun", 32'(overrun), 32'd0);
        tick();
        for (int i = 1; i < 16; i++) rd_chk($sformatf("t4_r%0d", i), 8'(8'h80 + i), 3'b000);
        rd_chk("t4_new", 8'hEE, 3'b000);
        chk("t4_empty", 32'(empty), 32'd1);

        // write and read together while empty: only the write happens
        done = 1'b1;
        data_in = 8'h77;
        rd_en = 1'b1;
        tick();
        done = 1'b0;
        rd_en = 1'b0;
        chk("we_count", 32'(count), 32'd1);
        chk("we_valid", 32'(rd_valid), 32'd0);
        tick();
        rd_chk("we_r", 8'h77, 3'b000);

        // 5: error flags and err_cnt
        send(8'hA5, 3'b001);
        send(8'h3C, 3'b010);
        chk("t5_errcnt", 32'(err_cnt), 32'd2);
        rd_chk("t5_r0", 8'hA5, 3'b001);
        rd_chk("t5_r1", 8'h3C, 3'b010);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("t5_errcnt_clr", 32'(err_cnt), 32'd0);
        chk("t5_ovr_clr", 32'(overrun), 32'd0);

        // clear coinciding with a counted write: write wins
        send(8'h11, 3'b100);
        send(8'h12, 3'b100);
        done = 1'b1;
        data_in = 8'h13;
        start_err = 1'b1;
        clr_status = 1'b1;
        tick();
        done = 1'b0;
        start_err = 1'b0;
        clr_status = 1'b0;
        chk("clr_vs_wr", 32'(err_cnt), 32'd1);
        tick();
        rd_chk("cw_r0", 8'h11, 3'b100);
        rd_chk("cw_r1", 8'h12, 3'b100);
        rd_chk("cw_r2", 8'h13, 3'b100);

        // err_cnt saturation
        for (int i = 0; i < 254; i++) begin
            send(8'(i), 3'b010);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        chk("sat_255", 32'(err_cnt), 32'd255);
        send(8'hFE, 3'b001);
        chk("sat_hold", 32'(err_cnt), 32'd255);
        rd_chk("sat_r", 8'hFE, 3'b001);

        // 6: asynchronous reset mid-read
        for (int i = 0; i < 5; i++) send(8'(8'hC0 + i), 3'b000);
        rd_en = 1'b1;
        tick();
        chk("t6_valid_pre", 32'(rd_valid), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_async_count", 32'(count), 32'd0);
        chk("t6_async_empty", 32'(empty), 32'd1);
        chk("t6_async_valid", 32'(rd_valid), 32'd0);
        chk("t6_async_data", 32'(rd_data), 32'd0);
        chk("t6_async_errcnt", 32'(err_cnt), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("t6_post_valid", 32'(rd_valid), 32'd0);
        chk("t6_post_empty", 32'(empty), 32'd1);
        rd_en = 1'b0;
        tick();

        for (int i = 0; i < 40; i++) begin
            send(8'(8'h20 + i * 3), 3'(i % 8));
            rd_chk($sformatf("t6_wrap%0d", i), 8'(8'h20 + i * 3), 3'(i % 8));
        end
        chk("t6_wrap_empty", 32'(empty), 32'd1);

        // done already high when reset releases yields one write
        rstn = 1'b0;
        done = 1'b1;
        data_in = 8'h99;
        tick();
        rstn = 1'b1;
        tick();
        chk("rel_count", 32'(count), 32'd1);
        tick();
        done = 1'b0;
        tick();
        chk("rel_count_hold", 32'(count), 32'd1);
        rd_chk("rel_r", 8'h99, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
